vec_alu_seq: RTL

- Time-multiplexed, parametrised vector ALU for signed fixed-point lanes (default Q7.8, 16 lanes).
- Processes PAR lanes per cycle through a shared datapath under a small FSM.
- Uses a valid/ready handshake on input and output, and supports a per-lane enable mask.
- Sits in the execution stage; registered results and per-lane C/N/V/Z flags feed vector writeback.

---
 rtl/vec_alu_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vec_alu_seq.sv
// Time-multiplexed signed fixed-point vector ALU: PAR lanes per beat, LANES/PAR beats per bundle.
// Optional clamp-on-overflow for ADD/SUB/MUL when VEC_ALU_SATURATE_EN is defined.
module vec_alu_seq #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned PAR        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    opcode,
  input  logic [LANES-1:0]              lane_mask,
  input  logic [LANES*DATA_WIDTH-1:0]   a,
  input  logic [LANES*DATA_WIDTH-1:0]   b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   result,
  output logic [LANES-1:0]              flag_c,
  output logic [LANES-1:0]              flag_n,
  output logic [LANES-1:0]              flag_v,
  output logic [LANES-1:0]              flag_z,
  output logic                          busy
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned BEATS = LANES / PAR;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LI_W  = (LANES > 1) ? $clog2(LANES) : 1;

  if ((LANES % PAR) != 0) begin : g_par_check
    $error("vec_alu_seq: LANES must be a multiple of PAR");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          c;
    logic          n;
    logic          v;
    logic          z;
  } lane_t;

  function automatic lane_t lane_op(input logic [1:0] op, input logic en,
                                    input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0]             sum;
    logic signed [DW-1:0]    xs, ys;
    logic signed [2*DW-1:0]  prod, shp;
    logic [DW-1:0]           r;
    logic                    c, v, neg;
    lane_t                   o;
    xs   = x;
    ys   = y;
    sum  = '0;
    prod = '0;
    shp  = '0;
    r    = x;
    c    = 1'b0;
    v    = 1'b0;
    neg  = 1'b0;
    case (op)
      2'b00: begin
        sum = {1'b0, x} + {1'b0, y};
        r   = sum[DW-1:0];
        c   = sum[DW];
        v   = (x[DW-1] == y[DW-1]) && (r[DW-1] != x[DW-1]);
        neg = x[DW-1];
      end
      2'b01: begin
        sum = {1'b0, x} - {1'b0, y};
        r   = sum[DW-1:0];
        c   = ~sum[DW];
        v   = (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
        neg = x[DW-1];
      end
      2'b10: begin
        prod = xs * ys;
        shp  = prod >>> FRAC_BITS;
        r    = shp[DW-1:0];
        // In range only if every bit above the result MSB equals it.
        v    = !((&shp[2*DW-1:DW-1]) || !(|shp[2*DW-1:DW-1]));
        c    = |(prod << (2*DW - FRAC_BITS));
        neg  = shp[2*DW-1];
      end
      default: begin
        r = (xs >= ys) ? x : y;
      end
    endcase
`ifdef VEC_ALU_SATURATE_EN
    if (v) r = neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    if (neg && 1'b0) r = '0;
`endif
    o.res = r;
    o.c   = c;
    o.v   = v;
    o.n   = r[DW-1];
    o.z   = (r == '0);
    if (!en) begin
      o     = '0;
      o.res = x;
    end
    return o;
  endfunction

  logic [DW-1:0] a_lane [LANES];
  logic [DW-1:0] b_lane [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign a_lane[g]             = a[g*DW +: DW];
    assign b_lane[g]             = b[g*DW +: DW];
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [DW-1:0]    a_q [LANES];
  logic [DW-1:0]    a_d [LANES];
  logic [DW-1:0]    b_q [LANES];
  logic [DW-1:0]    b_d [LANES];
  logic [DW-1:0]    res_q [LANES];
  logic [DW-1:0]    res_d [LANES];
  logic [LANES-1:0] c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;

  always_comb begin
    lane_t           l;
    logic [LI_W-1:0] li;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    l       = '0;
    li      = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          mask_d  = lane_mask;
          a_d     = a_lane;
          b_d     = b_lane;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int unsigned p = 0; p < PAR; p++) begin
          li        = LI_W'(32'(cnt_q) * PAR + p);
          l         = lane_op(op_q, mask_q[li], a_q[li], b_q[li]);
          res_d[li] = l.res;
          c_d[li]   = l.c;
          n_d[li]   = l.n;
          v_d[li]   = l.v;
          z_d[li]   = l.z;
        end
        if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_DONE;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      res_q   <= '{default: '0};
      c_q     <= '0;
      n_q     <= '0;
      v_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign result[g*DW +: DW] = res_q[g];
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign flag_z    = z_q;

endmodule
